// File: rtl/uart_tx.sv
// UART transmitter: start bit, DATA_WIDTH data bits (LSB first), optional parity, one stop bit.
// Each bit lasts max(PRESCALE,1) clocks; a new byte may be accepted in the last stop-bit cycle.
module uart_tx #(
    parameter int DATA_WIDTH  = 8,
    parameter int PRESC_WIDTH = 6
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic [DATA_WIDTH-1:0]  P_DATA,
    input  logic                   DATA_VALID,
    input  logic                   PAR_EN,
    input  logic                   PAR_TYP,
    input  logic [PRESC_WIDTH-1:0] PRESCALE,
    output logic                   TX_OUT,
    output logic                   Busy,
    output logic                   Frame_Done
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [4:0] {
        IDLE   = 5'b00001,
        START  = 5'b00010,
        DATA   = 5'b00100,
        PARITY = 5'b01000,
        STOP   = 5'b10000
    } state_t;

    state_t                 state;
    logic [PRESC_WIDTH-1:0] baud_cnt;
    logic [PRESC_WIDTH-1:0] bit_last;
    logic [IDX_W-1:0]       bit_idx;
    logic [DATA_WIDTH-1:0]  shift_reg;
    logic [DATA_WIDTH-1:0]  shift_nxt;
    logic                   par_en_q;
    logic                   par_bit;
    logic                   bit_end;
    logic                   accept;

    always_comb begin
        bit_last  = (PRESCALE == '0) ? '0 : PRESCALE - PRESC_WIDTH'(1);
        bit_end   = (baud_cnt == bit_last);
        accept    = DATA_VALID && ((state == IDLE) || ((state == STOP) && bit_end));
        shift_nxt = shift_reg >> 1;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= IDLE;
            TX_OUT     <= 1'b1;
            Busy       <= 1'b0;
            Frame_Done <= 1'b0;
            baud_cnt   <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            par_en_q   <= 1'b0;
            par_bit    <= 1'b0;
        end else begin
            Frame_Done <= 1'b0;
            if (state == IDLE || bit_end)
                baud_cnt <= '0;
            else
                baud_cnt <= baud_cnt + PRESC_WIDTH'(1);

            // Accept covers both IDLE and the final stop-bit cycle, so back-to-back frames share one path.
            if (accept) begin
                state     <= START;
                TX_OUT    <= 1'b0;
                Busy      <= 1'b1;
                shift_reg <= P_DATA;
                par_en_q  <= PAR_EN;
                par_bit   <= (^P_DATA) ^ PAR_TYP;
                bit_idx   <= '0;
                if (state == STOP)
                    Frame_Done <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        TX_OUT <= 1'b1;
                        Busy   <= 1'b0;
                    end
                    START: begin
                        if (bit_end) begin
                            state  <= DATA;
                            TX_OUT <= shift_reg[0];
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            shift_reg <= shift_nxt;
                            if (bit_idx == IDX_W'(DATA_WIDTH - 1)) begin
                                bit_idx <= '0;
                                if (par_en_q) begin
                                    state  <= PARITY;
                                    TX_OUT <= par_bit;
                                end else begin
                                    state  <= STOP;
                                    TX_OUT <= 1'b1;
                                end
                            end else begin
                                bit_idx <= bit_idx + IDX_W'(1);
                                TX_OUT  <= shift_nxt[0];
                            end
                        end
                    end
                    PARITY: begin
                        if (bit_end) begin
                            state  <= STOP;
                            TX_OUT <= 1'b1;
                        end
                    end
                    STOP: begin
                        if (bit_end) begin
                            state      <= IDLE;
                            TX_OUT     <= 1'b1;
                            Busy       <= 1'b0;
                            Frame_Done <= 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        TX_OUT   <= 1'b1;
                        Busy     <= 1'b0;
                        baud_cnt <= '0;
                        bit_idx  <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: directed frames plus random traffic checked cycle by cycle
// against a queue of expected line levels built from the frame format.
module tb_uart_tx;

    localparam int DW = 8;
    localparam int PW = 6;

    logic          CLK = 1'b0;
    logic          RST;
    logic [DW-1:0] P_DATA;
    logic          DATA_VALID;
    logic          PAR_EN;
    logic          PAR_TYP;
    logic [PW-1:0] PRESCALE;
    logic          TX_OUT;
    logic          Busy;
    logic          Frame_Done;

    always #5 CLK = ~CLK;

    uart_tx #(.DATA_WIDTH(DW), .PRESC_WIDTH(PW)) dut (
        .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
        .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .PRESCALE(PRESCALE),
        .TX_OUT(TX_OUT), .Busy(Busy), .Frame_Done(Frame_Done)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;
    int unsigned cyc = 0;
    int unsigned acc_cnt = 0;
    int unsigned last_done_cyc = 0;
    int unsigned done_gap = 0;
    bit          exp_q[$];
    logic        exp_tx = 1'b1;
    logic        exp_busy = 1'b0;
    logic        exp_done = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected line level for every cycle of one frame
    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                              input int unsigned p);
        bit bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (pe) bits.push_back((^d) ^ pt);
        bits.push_back(1'b1);
        foreach (bits[i])
            for (int unsigned j = 0; j < p; j++) exp_q.push_back(bits[i]);
    endtask

    task automatic tick();
        bit idle;
        bit last;
        int unsigned p_eff;
        @(posedge CLK);
        if (RST) begin
            exp_q.delete();
            exp_tx = 1'b1; exp_busy = 1'b0; exp_done = 1'b0;
        end else begin
            idle = (exp_q.size() == 0);
            last = (exp_q.size() == 1);
            if (!idle) void'(exp_q.pop_front());
            if (DATA_VALID && (idle || last)) begin
                p_eff = (PRESCALE == '0) ? 1 : int'(PRESCALE);
                push_frame(P_DATA, PAR_EN, PAR_TYP, p_eff);
                acc_cnt++;
            end
            exp_done = last;
            exp_busy = (exp_q.size() != 0);
            exp_tx   = exp_busy ? exp_q[0] : 1'b1;
        end
        @(negedge CLK);
        cyc++;
        check_eq("tx_out", TX_OUT, exp_tx);
        check_eq("busy", Busy, exp_busy);
        check_eq("frame_done", Frame_Done, exp_done);
        if (Frame_Done) begin
            done_gap = cyc - last_done_cyc;
            last_done_cyc = cyc;
        end
    endtask

    task automatic wait_idle(input int unsigned limit);
        int unsigned n = 0;
        while (exp_q.size() != 0 && n < limit) begin
            tick();
            n++;
        end
        check_eq("idle_timeout", (exp_q.size() == 0), 1);
    endtask

    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pt,
                        input logic [PW-1:0] p);
        int unsigned a0;
        wait_idle(5000);
        P_DATA = d; PAR_EN = pe; PAR_TYP = pt; PRESCALE = p;
        DATA_VALID = 1'b1;
        a0 = acc_cnt;
        tick();
        DATA_VALID = 1'b0;
        check_eq("accept", acc_cnt - a0, 1);
    endtask

    // Measure Busy length of the frame just accepted and confirm Frame_Done follows it
    task automatic run_frame(input string tag, input int unsigned exp_len);
        int unsigned n = 1;
        while (Busy && n < 5000) begin
            P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
            tick();
            if (Busy) n++;
        end
        check_eq({tag, "_len"}, n, exp_len);
        check_eq({tag, "_done"}, Frame_Done, 1);
        tick();
    endtask

    initial begin
        int unsigned a0;
        int unsigned p;
        int unsigned n;
        RST = 1'b1; P_DATA = '0; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0; PRESCALE = PW'(1);
        #1;
        check_eq("rst_tx", TX_OUT, 1);
        check_eq("rst_busy", Busy, 0);
        check_eq("rst_done", Frame_Done, 0);
        repeat (3) tick();
        RST = 1'b0;
        tick();

        // Reset in the middle of the data bits
        send(8'hC3, 1'b0, 1'b0, PW'(4));
        repeat (9) tick();
        #2 RST = 1'b1;
        #1;
        check_eq("arst_tx", TX_OUT, 1);
        check_eq("arst_busy", Busy, 0);
        check_eq("arst_done", Frame_Done, 0);
        repeat (2) tick();
        RST = 1'b0;
        repeat (3) tick();
        send(8'hC3, 1'b0, 1'b0, PW'(4));
        run_frame("post_rst", 40);

        send(8'hA5, 1'b0, 1'b0, PW'(1));
        run_frame("a5_nopar", 10);
        send(8'hA5, 1'b1, 1'b0, PW'(1));
        run_frame("a5_even", 11);
        send(8'hA5, 1'b1, 1'b1, PW'(1));
        run_frame("a5_odd", 11);
        send(8'h3C, 1'b0, 1'b0, PW'(16));
        run_frame("3c_p16", 160);
        send(8'h96, 1'b1, 1'b1, PW'(0));
        run_frame("p0", 11);
        send(8'h00, 1'b1, 1'b0, PW'(63));
        run_frame("p63", 693);

        // Back-to-back frames with DATA_VALID held
        wait_idle(5000);
        PRESCALE = PW'(2); PAR_EN = 1'b0; P_DATA = 8'h01; DATA_VALID = 1'b1;
        a0 = acc_cnt;
        tick();
        P_DATA = 8'hFF;
        n = 0;
        while (acc_cnt != a0 + 2 && n < 100) begin
            tick();
            n++;
        end
        DATA_VALID = 1'b0;
        check_eq("b2b_accepts", acc_cnt - a0, 2);
        wait_idle(100);
        tick();
        check_eq("b2b_gap", done_gap, 20);

        // Mid-frame DATA_VALID pulse is ignored
        send(8'h0F, 1'b0, 1'b0, PW'(3));
        repeat (7) tick();
        a0 = acc_cnt;
        P_DATA = 8'h55; DATA_VALID = 1'b1;
        tick();
        DATA_VALID = 1'b0;
        wait_idle(100);
        repeat (3) tick();
        check_eq("midframe_ignored", acc_cnt - a0, 0);

        // Random traffic: random pulses during frames may land on the stop-bit end
        for (int k = 0; k < 200; k++) begin
            wait_idle(5000);
            repeat ($urandom_range(0, 2)) tick();
            p = ($urandom_range(0, 31) == 0) ? 63 : $urandom_range(0, 5);
            P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
            PRESCALE = PW'(p);
            DATA_VALID = 1'b1;
            tick();
            n = 0;
            while (exp_q.size() != 0 && n < 20000) begin
                P_DATA = DW'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
                DATA_VALID = ($urandom_range(0, 15) == 0);
                tick();
                n++;
            end
            DATA_VALID = 1'b0;
            check_eq("rand_timeout", (n < 20000), 1);
        end
        wait_idle(5000);
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
